// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and flag bit indices for the ALU issue/writeback stage
package alu_pkg;
  localparam int DW = 8;
  localparam int NREG = 8;
  localparam int RW = $clog2(NREG);
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_MUL  = 4'b0010, OP_DIV  = 4'b0011,
    OP_SHL  = 4'b0100, OP_SHR  = 4'b0101, OP_ROL  = 4'b0110, OP_ROR  = 4'b0111,
    OP_AND  = 4'b1000, OP_OR   = 4'b1001, OP_XOR  = 4'b1010, OP_NOR  = 4'b1011,
    OP_NAND = 4'b1100, OP_XNOR = 4'b1101
  } op_e;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGxDW register file, r0 reads zero, write port i_we/i_waddr/i_wdata, three async read ports
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_raddr1,
  input  logic [RW-1:0] i_raddr2,
  input  logic [RW-1:0] i_raddr3,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2,
  output logic [DW-1:0] o_rdata3
);
  logic [DW-1:0] r_mem [NREG];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    else if (i_we && i_waddr != '0) r_mem[i_waddr] <= i_wdata;
  assign o_rdata1 = i_raddr1 == '0 ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = i_raddr2 == '0 ? '0 : r_mem[i_raddr2];
  assign o_rdata3 = i_raddr3 == '0 ? '0 : r_mem[i_raddr3];
endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: operand fetch with forwarding, ALU operand registers (alu_*), result/flag commit (wb_*, flags), sticky div0 halt, debug read
module alu_issue_wb
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_rs1,
  input  logic [RW-1:0] instr_rs2,
  input  logic          instr_use_imm,
  input  logic [DW-1:0] instr_imm,
  input  logic [2:0]    instr_shamt,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_shift,
  output logic [3:0]    alu_fsel,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  output logic [3:0]    flags,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic          div0_err,
  input  logic          clear_err,
  input  logic [RW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);
  logic          r_ex_valid;
  logic [RW-1:0] r_ex_rd;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [2:0]    r_alu_shift;
  logic [3:0]    r_alu_fsel;
  logic [3:0]    r_flags;
  logic          r_wb_valid;
  logic [RW-1:0] r_wb_rd;
  logic          r_div0_err;
  logic          w_ex_div0;
  logic          w_commit;
  logic          w_accept;
  logic [DW-1:0] w_rs1_data;
  logic [DW-1:0] w_rs2_data;
  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;
  assign w_ex_div0   = r_ex_valid && r_alu_fsel == OP_DIV && r_alu_b == '0;
  assign w_commit    = r_ex_valid && !w_ex_div0;
  assign instr_ready = !r_div0_err && !w_ex_div0;
  assign w_accept    = instr_valid && instr_ready;
  assign w_fwd_a = instr_rs1 == '0 ? '0 : (w_commit && r_ex_rd == instr_rs1) ? alu_result : w_rs1_data;
  assign w_fwd_b = instr_rs2 == '0 ? '0 : (w_commit && r_ex_rd == instr_rs2) ? alu_result : w_rs2_data;
  alu_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_commit),
    .i_waddr  (r_ex_rd),
    .i_wdata  (alu_result),
    .i_raddr1 (instr_rs1),
    .i_raddr2 (instr_rs2),
    .i_raddr3 (dbg_raddr),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data),
    .o_rdata3 (dbg_rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_shift <= '0;
      r_alu_fsel  <= '0;
      r_flags     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_div0_err  <= 1'b0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_rd     <= instr_rd;
        r_alu_fsel  <= instr_op;
        r_alu_shift <= instr_shamt;
        r_alu_a     <= w_fwd_a;
        r_alu_b     <= instr_use_imm ? instr_imm : w_fwd_b;
      end
      r_wb_valid <= w_commit;
      if (w_commit) begin
        r_wb_rd <= r_ex_rd;
        r_flags <= {alu_zero, alu_neg, alu_carry, alu_overflow};
      end
      r_div0_err <= w_ex_div0 || (r_div0_err && !clear_err);
    end
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_shift = r_alu_shift;
  assign alu_fsel  = r_alu_fsel;
  assign flags     = r_flags;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign div0_err  = r_div0_err;
endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed vector table, hand-written halt/reset sequences and a random run against an architectural model
`timescale 1ns/1ps
module tb_alu_issue_wb;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0;
  logic [2:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic       instr_use_imm = 1'b0;
  logic [7:0] instr_imm = '0;
  logic [2:0] instr_shamt = '0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_shift;
  logic [3:0] alu_fsel;
  logic [7:0] alu_result;
  logic       alu_zero, alu_neg, alu_carry, alu_overflow;
  logic [3:0] flags;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic       div0_err;
  logic       clear_err = 1'b0;
  logic [2:0] dbg_raddr = '0;
  logic [7:0] dbg_rdata;
  logic [11:0] alu_o;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_wb dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm), .instr_shamt(instr_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shift(alu_shift), .alu_fsel(alu_fsel),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .flags(flags), .wb_valid(wb_valid), .wb_rd(wb_rd), .div0_err(div0_err),
    .clear_err(clear_err), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  // Behavioural 8-bit ALU: returns {result, Z, N, C, V}; C is carry for ADD, borrow for SUB
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sh);
    logic [7:0] r;
    logic [15:0] w;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0; w = {a, a};
    case (op)
      4'h0: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h1: begin r = a - b; c = a < b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h2: begin w = a * b; r = w[7:0]; end
      4'h3: r = (b == 8'h0) ? 8'h0 : a / b;
      4'h4: r = a << sh;
      4'h5: r = a >> sh;
      4'h6: begin w = w << sh; r = w[15:8]; end
      4'h7: begin w = w >> sh; r = w[7:0]; end
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      default: r = '0;
    endcase
    return {r, r == 8'h0, r[7], c, v};
  endfunction

  always_comb alu_o = alu_f(alu_fsel, alu_a, alu_b, alu_shift);
  assign {alu_result, alu_zero, alu_neg, alu_carry, alu_overflow} = alu_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic ui, input logic [7:0] imm, input logic [2:0] sh);
    instr_valid = v; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_use_imm = ui; instr_imm = imm; instr_shamt = sh;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic       ui;
    logic [7:0] imm;
    logic [2:0] sh;
    logic [7:0] exp_val;
    logic [3:0] exp_fl;
  } vec_t;
  vec_t tbl [13];

  logic [7:0]  m_regs [8];
  logic [3:0]  m_flags;
  logic        m_err, m_wbv, p_valid, p_div0, acc, exp_ready, clr, v;
  logic [2:0]  m_wbrd, p_rd, rd, rs1, rs2, sh;
  logic [7:0]  p_res, ma, mb, imm;
  logic [3:0]  p_fl, op;
  logic        ui;
  logic [11:0] t;

  initial begin
    tbl[0]  = '{4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 3'd0, 8'h05, 4'b0000};
    tbl[1]  = '{4'h0, 3'd2, 3'd0, 3'd0, 1'b1, 8'h03, 3'd0, 8'h03, 4'b0000};
    tbl[2]  = '{4'h1, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 3'd0, 8'h02, 4'b0000};
    tbl[3]  = '{4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hF0, 3'd0, 8'hF0, 4'b0100};
    tbl[4]  = '{4'h0, 3'd4, 3'd1, 3'd0, 1'b1, 8'h20, 3'd0, 8'h10, 4'b0010};
    tbl[5]  = '{4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 3'd0, 8'h7F, 4'b0000};
    tbl[6]  = '{4'h0, 3'd5, 3'd1, 3'd0, 1'b1, 8'h01, 3'd0, 8'h80, 4'b0101};
    tbl[7]  = '{4'h0, 3'd0, 3'd0, 3'd0, 1'b1, 8'h09, 3'd0, 8'h00, 4'b0000};
    tbl[8]  = '{4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h81, 3'd0, 8'h81, 4'b0100};
    tbl[9]  = '{4'h4, 3'd6, 3'd1, 3'd0, 1'b0, 8'h00, 3'd1, 8'h02, 4'b0000};
    tbl[10] = '{4'h6, 3'd7, 3'd1, 3'd0, 1'b0, 8'h00, 3'd1, 8'h03, 4'b0000};
    tbl[11] = '{4'hE, 3'd2, 3'd1, 3'd3, 1'b0, 8'h00, 3'd0, 8'h00, 4'b1000};
    tbl[12] = '{4'h8, 3'd3, 3'd1, 3'd0, 1'b1, 8'h80, 3'd0, 8'h80, 4'b0100};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_flags", flags, 0);

    // Directed vectors issued back-to-back; each commit is visible two negedges after it is driven
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if (i < 13) drive(1'b1, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].ui, tbl[i].imm, tbl[i].sh);
      else instr_valid = 1'b0;
      if (i >= 2) begin
        dbg_raddr = tbl[i-2].rd;
        #1;
        chk($sformatf("vec%0d_wb_valid", i-2), wb_valid, 1);
        chk($sformatf("vec%0d_wb_rd", i-2), wb_rd, tbl[i-2].rd);
        chk($sformatf("vec%0d_flags", i-2), flags, tbl[i-2].exp_fl);
        chk($sformatf("vec%0d_rd_val", i-2), dbg_rdata, tbl[i-2].exp_val);
      end
      if (i < 13) chk($sformatf("vec%0d_ready", i), instr_ready, 1);
    end

    // Divide by zero: r5 = r1 / r0, then an instruction held valid through the halt
    @(negedge clk);
    drive(1'b1, 4'h3, 3'd5, 3'd1, 3'd0, 1'b0, 8'h00, 3'd0);
    @(negedge clk);
    drive(1'b1, 4'h0, 3'd4, 3'd0, 3'd0, 1'b1, 8'hC3, 3'd0);
    #1;
    chk("div0_ex_ready", instr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dbg_raddr = 3'd5;
      #1;
      chk("div0_err_set", div0_err, 1);
      chk("div0_halt_ready", instr_ready, 0);
      chk("div0_no_wb", wb_valid, 0);
      chk("div0_flags_kept", flags, 4'b0100);
      chk("div0_r5_kept", dbg_rdata, 8'h80);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    #1;
    chk("clear_err", div0_err, 0);
    chk("clear_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    dbg_raddr = 3'd4;
    #1;
    chk("held_wb_valid", wb_valid, 1);
    chk("held_wb_rd", wb_rd, 4);
    chk("held_r4", dbg_rdata, 8'hC3);
    chk("held_flags", flags, 4'b0100);

    // Reset while an instruction sits in EX
    drive(1'b1, 4'h0, 3'd6, 3'd0, 3'd0, 1'b1, 8'h55, 3'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    instr_valid = 1'b0;
    #1;
    chk("mrst_wb_valid", wb_valid, 0);
    chk("mrst_wb_rd", wb_rd, 0);
    chk("mrst_flags", flags, 0);
    chk("mrst_err", div0_err, 0);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_alu_b", alu_b, 0);
    chk("mrst_alu_shift", alu_shift, 0);
    chk("mrst_alu_fsel", alu_fsel, 0);
    chk("mrst_ready", instr_ready, 1);
    for (int a = 0; a < 8; a++) begin
      dbg_raddr = 3'(a);
      #1;
      chk($sformatf("mrst_dbg_r%0d", a), dbg_rdata, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dbg_raddr = 3'd6;
    #1;
    chk("mrst_no_wb", wb_valid, 0);
    chk("mrst_r6_zero", dbg_rdata, 0);

    // Random run against an in-order architectural model (state is all-zero after the reset above)
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0; m_err = 1'b0; m_wbv = 1'b0; m_wbrd = '0; p_valid = 1'b0; p_div0 = 1'b0;
    p_rd = '0; p_res = '0; p_fl = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      dbg_raddr = 3'($urandom_range(0, 7));
      #1;
      chk("rnd_wb_valid", wb_valid, m_wbv);
      if (m_wbv) chk("rnd_wb_rd", wb_rd, m_wbrd);
      chk("rnd_flags", flags, m_flags);
      chk("rnd_err", div0_err, m_err);
      chk("rnd_dbg", dbg_rdata, m_regs[dbg_raddr]);
      v   = $urandom_range(0, 3) != 0;
      op  = ($urandom_range(0, 4) == 0) ? 4'h3 : 4'($urandom_range(0, 15));
      rd  = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      rs2 = 3'($urandom_range(0, 7));
      ui  = 1'($urandom_range(0, 1));
      imm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sh  = 3'($urandom_range(0, 7));
      clr = $urandom_range(0, 5) == 0;
      drive(v, op, rd, rs1, rs2, ui, imm, sh);
      clear_err = clr;
      #1;
      exp_ready = !m_err && !(p_valid && p_div0);
      chk("rnd_ready", instr_ready, exp_ready);
      acc = v && exp_ready;
      if (p_valid && !p_div0) begin
        if (p_rd != 3'd0) m_regs[p_rd] = p_res;
        m_flags = p_fl;
        m_wbv = 1'b1;
        m_wbrd = p_rd;
      end else m_wbv = 1'b0;
      if (p_valid && p_div0) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      p_valid = acc;
      if (acc) begin
        ma = m_regs[rs1];
        mb = ui ? imm : m_regs[rs2];
        t = alu_f(op, ma, mb, sh);
        p_res = t[11:4];
        p_fl = t[3:0];
        p_div0 = op == 4'h3 && mb == 8'h00;
        p_rd = rd;
      end
    end
    instr_valid = 1'b0;
    clear_err = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Operand-fetch / writeback stage wrapped around the 8-bit ALU of the MCU datapath.
- Accepts decoded ALU instructions over a valid/ready handshake and reads two operands from an 8x8 register file, forwarding the in-flight result when needed.
- Registers A, B, shift and function_select into the ALU, then commits the ALU result and flags at the end of the execute cycle.
- Detects divide-by-zero and halts issue until software clears the error.

Parameters:
- DW, 8, data width (matches ALU operands).
- NREG, 8, register count; register index width is clog2(NREG) = 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decoded instruction present.
- instr_ready  out  1  stage can accept.
- instr_op  in  4  ALU function_select code.
- instr_rd  in  3  destination register.
- instr_rs1  in  3  source A register.
- instr_rs2  in  3  source B register.
- instr_use_imm  in  1  B comes from instr_imm instead of rs2.
- instr_imm  in  8  immediate operand.
- instr_shamt  in  3  shift amount.
- alu_a  out  8  registered operand A to ALU.
- alu_b  out  8  registered operand B to ALU.
- alu_shift  out  3  registered shift amount.
- alu_fsel  out  4  registered function_select.
- alu_result  in  8  ALU_Result (combinational from alu_* outputs).
- alu_zero, alu_neg, alu_carry, alu_overflow  in  1 each  ALU flags.
- flags  out  4  committed {Z,N,C,V}.
- wb_valid  out  1  one-cycle pulse: a write committed on the previous edge.
- wb_rd  out  3  register written (valid with wb_valid).
- div0_err  out  1  sticky divide-by-zero error.
- clear_err  in  1  clears div0_err.
- dbg_raddr  in  3  debug read address.
- dbg_rdata  out  8  debug read data (combinational).

Behaviour:
- Reset (async, rst=1):
  - all registers cleared to 0.
  - ex_valid=0, ex_rd=0.
  - alu_a, alu_b, alu_shift, alu_fsel = 0.
  - flags=0, wb_valid=0, wb_rd=0, div0_err=0.
  - Reset mid-instruction discards the instruction; no write occurs.
- r0 reads as 0; writes to r0 are dropped. Flags still update on such writes; wb_valid still pulses.
- Handshake and issue:
  - Accept = instr_valid & instr_ready at a rising edge.
  - On accept: EX regs load. ex_valid=1; ex_rd=instr_rd; alu_fsel=instr_op; alu_shift=instr_shamt; alu_a=fwd(rs1); alu_b = use_imm ? imm : fwd(rs2).
  - No accept: ex_valid=0 next cycle. alu_* hold their values.
- Forwarding: fwd(r) = 0 if r==0; else alu_result if ex_valid & ~ex_div0 & ex_rd==r; else regfile[r].
- Execute: ex_div0 = ex_valid & alu_fsel==4'b0011 & alu_b==0 (combinational).
- Commit, at the edge ending an EX cycle with ex_valid & ~ex_div0:
  - regfile[ex_rd] <= alu_result (if ex_rd != 0).
  - flags <= {alu_zero, alu_neg, alu_carry, alu_overflow}.
  - wb_valid <= 1 and wb_rd <= ex_rd; otherwise wb_valid <= 0.
- Divide-by-zero, at the edge ending a faulting EX cycle:
  - no register write; flags unchanged.
  - div0_err <= 1.
- Error clearing: clear_err=1 clears div0_err. If a new div0 occurs in the same cycle, the set wins.
- instr_ready = ~div0_err & ~ex_div0. An instruction offered during a faulting cycle is not accepted.
- Throughput and latency:
  - one instruction per cycle; no stalls except the error halt.
  - result visible in regfile/flags/dbg_rdata one cycle after the accept edge.
  - back-to-back dependent instructions need no bubble.
- Opcodes 1110/1111: the ALU yields 0. Commit them normally: rd written with 0, Z=1.
- The debug read port sees committed state only (no forwarding).

Decomposition:
- Shared package alu_pkg:
  - opcode constants (OP_ADD=0000 ... OP_XNOR=1101, OP_DIV=0011).
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - DW and register-index width.
- One sub-module: alu_regfile.
  - 8x8 with async reset.
  - three combinational read ports (rs1, rs2, dbg) and one write port.
  - r0 hardwired to zero.

Test Plan:
- Reset with rst asserted mid-stream -> all outputs 0, instr_ready=1, dbg_rdata=0 for every address.
- r1<=imm 5 (ADD r0+imm), r2<=imm 3, then SUB r3=r1-r2 issued back-to-back -> forwarding gives r3=2, wb_valid pulses 3 cycles in a row, flags Z=0, N=0.
- ADD r4 = r1(0xF0) + imm 0x20 -> r4=0x10, C=1.
- ADD with 0x7F + 0x01 -> result 0x80, N=1, V=1.
- DIV r5 = r1 / r0 -> no write, flags unchanged, div0_err=1, instr_ready=0 with instr_valid held high. Then clear_err -> ready returns and the held instruction issues.
- Write to r0 (ADD r0=imm 9) -> dbg_raddr=0 reads 0; flags update; wb_valid=1, wb_rd=0.
- SHL r6 = r1(0x81) shamt 1 -> 0x02.
- Rotate-left of 0x81 -> 0x03.
